motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pwm_driver_pkg.sv | 48 ++++
 rtl/motor_pwm_driver_canal.sv | 114 +++++++++++
 rtl/motor_pwm_driver.sv | 82 ++++++++
 tb/tb_motor_pwm_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_driver_pkg.sv
// Shared encodings and BCD helpers for the dual-channel H-bridge PWM driver.
package motor_pwm_driver_pkg;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_STP = 2'b00;

    localparam logic [11:0] BCD_MAX = 12'h999;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_DEAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // Three-digit BCD increment with wrap 999 -> 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == BCD_MAX) begin
            r = 12'h000;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    // Any non-decimal digit saturates the duty to full scale.
    function automatic logic [11:0] bcd_clean(input logic [11:0] v);
        if ((v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9)) begin
            return BCD_MAX;
        end
        return v;
    endfunction

    function automatic logic dir_is_run(input logic [1:0] d);
        return (d == DIR_FWD) || (d == DIR_REV);
    endfunction

endpackage

// File: rtl/motor_pwm_driver_canal.sv
// One H-bridge channel: period-synchronous state machine, duty latch, PWM compare and pin drive.
module canal_motor
    import motor_pwm_driver_pkg::*;
#(
    parameter int DEAD_PER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_start,
    input  logic [11:0] count,
    input  logic [1:0]  dir_req,
    input  logic [11:0] duty_req,
    output logic        pin_hi,
    output logic        pin_lo,
    output logic        pwm,
    output logic [1:0]  stare
);

    localparam int DW = (DEAD_PER > 1) ? $clog2(DEAD_PER + 1) : 1;

    state_e      state_q, state_n;
    logic [1:0]  dir_q, dir_n;
    logic [11:0] duty_q, duty_n;
    logic [DW-1:0] dead_q, dead_n;
    logic [1:0]  pins_q;
    logic        pwm_q;

    // Requests are only looked at on the period boundary; everything else holds.
    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        duty_n  = duty_q;
        dead_n  = dead_q;
        if (per_start) begin
            case (state_q)
                ST_STOP: begin
                    if (dir_is_run(dir_req)) begin
                        state_n = ST_RUN;
                        dir_n   = dir_req;
                        duty_n  = bcd_clean(duty_req);
                    end
                end
                ST_RUN: begin
                    if (!dir_is_run(dir_req)) begin
                        state_n = ST_STOP;
                        dir_n   = DIR_STP;
                    end else if (dir_req == dir_q) begin
                        duty_n = bcd_clean(duty_req);
                    end else begin
                        state_n = ST_DEAD;
                        dead_n  = DW'(DEAD_PER);
                    end
                end
                ST_DEAD: begin
                    // A zero load still costs one full period, so pins never flip directly.
                    if (dead_q <= DW'(1)) begin
                        dead_n = '0;
                        if (dir_is_run(dir_req)) begin
                            state_n = ST_RUN;
                            dir_n   = dir_req;
                            duty_n  = bcd_clean(duty_req);
                        end else begin
                            state_n = ST_STOP;
                            dir_n   = DIR_STP;
                        end
                    end else begin
                        dead_n = dead_q - DW'(1);
                    end
                end
                default: begin
                    state_n = ST_STOP;
                    dir_n   = DIR_STP;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so pins and state switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            dir_q   <= DIR_STP;
            duty_q  <= 12'h000;
            dead_q  <= '0;
            pins_q  <= 2'b00;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            duty_q  <= duty_n;
            dead_q  <= dead_n;
            case (state_n)
                ST_STOP: begin
                    pins_q <= 2'b11;
                    pwm_q  <= 1'b1;
                end
                ST_RUN: begin
                    pins_q <= dir_n;
                    pwm_q  <= (count < duty_n);
                end
                default: begin
                    pins_q <= 2'b00;
                    pwm_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pin_hi = pins_q[1];
    assign pin_lo = pins_q[0];
    assign pwm    = pwm_q;
    assign stare  = state_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared prescaler and BCD period counter feeding two channels.
module motor_pwm_driver
    import motor_pwm_driver_pkg::*;
#(
    parameter int PRESC    = 50,
    parameter int DEAD_PER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  directie_driverA,
    input  logic [1:0]  directie_driverB,
    input  logic [11:0] factor_dc_driverA,
    input  logic [11:0] factor_dc_driverB,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic [1:0]  stare_a,
    output logic [1:0]  stare_b,
    output logic        per_start
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] presc_cnt;
    logic          tick;
    logic [11:0]   bcd_cnt;

    assign tick = (presc_cnt == PW'(PRESC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // per_start is high for the single clk in which the counter has just wrapped to 000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_cnt   <= 12'h000;
            per_start <= 1'b0;
        end else if (tick) begin
            bcd_cnt   <= bcd_inc(bcd_cnt);
            per_start <= (bcd_cnt == BCD_MAX);
        end else begin
            per_start <= 1'b0;
        end
    end

    canal_motor #(.DEAD_PER(DEAD_PER)) u_canal_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .per_start (per_start),
        .count     (bcd_cnt),
        .dir_req   (directie_driverA),
        .duty_req  (factor_dc_driverA),
        .pin_hi    (in1),
        .pin_lo    (in2),
        .pwm       (pwm_a),
        .stare     (stare_a)
    );

    canal_motor #(.DEAD_PER(DEAD_PER)) u_canal_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .per_start (per_start),
        .count     (bcd_cnt),
        .dir_req   (directie_driverB),
        .duty_req  (factor_dc_driverB),
        .pin_hi    (in3),
        .pin_lo    (in4),
        .pwm       (pwm_b),
        .stare     (stare_b)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed period table, async reset sequence, random vs. model.
module tb_motor_pwm_driver;

    localparam int DEAD_PER = 2;
    localparam int M_STOP = 0;
    localparam int M_DEAD = 1;
    localparam int M_RUN  = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dir_a, dir_b;
    logic [11:0] duty_a, duty_b;
    logic        in1, in2, in3, in4;
    logic        pwm_a, pwm_b;
    logic [1:0]  stare_a, stare_b;
    logic        per_start;

    int checks = 0;
    int errors = 0;
    int n = 0;

    int         m_mode[2];
    logic [1:0] m_dir[2];
    int         m_duty[2];
    int         m_dead[2];

    typedef struct {
        logic [1:0]  dir;
        logic [11:0] duty;
        logic [1:0]  exp_stare;
        logic [1:0]  exp_pins;
        int          exp_highs;
    } vec_t;

    vec_t vecs[13];

    motor_pwm_driver #(.PRESC(1), .DEAD_PER(DEAD_PER)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .directie_driverA  (dir_a),
        .directie_driverB  (dir_b),
        .factor_dc_driverA (duty_a),
        .factor_dc_driverB (duty_b),
        .in1               (in1),
        .in2               (in2),
        .in3               (in3),
        .in4               (in4),
        .pwm_a             (pwm_a),
        .pwm_b             (pwm_b),
        .stare_a           (stare_a),
        .stare_b           (stare_b),
        .per_start         (per_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, n, got, exp);
        end
    endtask

    function automatic int bcd_value(input logic [11:0] d);
        if (d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) return 999;
        return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [11:0] random_duty();
        logic [11:0] d;
        d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) d[7:4] = 4'($urandom_range(10, 15));
        return d;
    endfunction

    // Period-level behaviour of one channel, applied once at each period boundary.
    task automatic model_period(input int ch, input logic [1:0] req, input logic [11:0] duty);
        bit go;
        go = (req == 2'b10) || (req == 2'b01);
        case (m_mode[ch])
            M_STOP: if (go) begin
                m_mode[ch] = M_RUN; m_dir[ch] = req; m_duty[ch] = bcd_value(duty);
            end
            M_RUN: begin
                if (!go) m_mode[ch] = M_STOP;
                else if (req == m_dir[ch]) m_duty[ch] = bcd_value(duty);
                else begin m_mode[ch] = M_DEAD; m_dead[ch] = DEAD_PER; end
            end
            default: begin
                m_dead[ch] = m_dead[ch] - 1;
                if (m_dead[ch] <= 0) begin
                    if (go) begin
                        m_mode[ch] = M_RUN; m_dir[ch] = req; m_duty[ch] = bcd_value(duty);
                    end else m_mode[ch] = M_STOP;
                end
            end
        endcase
    endtask

    // Expected {pin pair, pwm, state} after clk edge number n.
    function automatic logic [4:0] exp_chan(input int ch);
        case (m_mode[ch])
            M_STOP: return {2'b11, 1'b1, 2'b00};
            M_DEAD: return {2'b00, 1'b0, 2'b01};
            default: return {m_dir[ch], (((n - 1) % 1000) < m_duty[ch]), 2'b10};
        endcase
    endfunction

    task automatic step();
        logic [1:0]  ra, rb;
        logic [11:0] da, db;
        ra = dir_a; rb = dir_b; da = duty_a; db = duty_b;
        @(posedge clk);
        n++;
        if (n > 1 && ((n - 1) % 1000) == 0) begin
            model_period(0, ra, da);
            model_period(1, rb, db);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dir_a = 2'b00; dir_b = 2'b00; duty_a = 12'h000; duty_b = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_outputs", {in1, in2, in3, in4, pwm_a, pwm_b, stare_a, stare_b, per_start}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = M_STOP; m_dir[c] = 2'b00; m_duty[c] = 0; m_dead[c] = 0;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        dir_a  = v.dir;
        duty_a = v.duty;
        dir_b  = 2'b00;
        duty_b = 12'h000;
    endtask

    initial begin
        int wait_cnt, highs, shape, steady, first_ps;
        logic [1:0] first_pins, prev_a, prev_b, cur_a, cur_b;
        logic exp_bit;

        vecs[0]  = '{2'b10, 12'h500, 2'b10, 2'b10, 500};
        vecs[1]  = '{2'b10, 12'h000, 2'b10, 2'b10, 0};
        vecs[2]  = '{2'b10, 12'h999, 2'b10, 2'b10, 999};
        vecs[3]  = '{2'b01, 12'h250, 2'b01, 2'b00, 0};
        vecs[4]  = '{2'b01, 12'h250, 2'b01, 2'b00, 0};
        vecs[5]  = '{2'b01, 12'h250, 2'b10, 2'b01, 250};
        vecs[6]  = '{2'b00, 12'h9A0, 2'b00, 2'b11, 1000};
        vecs[7]  = '{2'b10, 12'h9A0, 2'b10, 2'b10, 999};
        vecs[8]  = '{2'b11, 12'h123, 2'b00, 2'b11, 1000};
        vecs[9]  = '{2'b01, 12'h050, 2'b10, 2'b01, 50};
        vecs[10] = '{2'b10, 12'h300, 2'b01, 2'b00, 0};
        vecs[11] = '{2'b00, 12'h300, 2'b01, 2'b00, 0};
        vecs[12] = '{2'b00, 12'h300, 2'b00, 2'b11, 1000};

        do_reset();
        step();
        check_output("first_edge_stop", {in1, in2, in3, in4, pwm_a, pwm_b, stare_a, stare_b}, 12'b1111_11_00_00 << 0);

        $display("[TB] directed period table");
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i]);
            wait_cnt = 0;
            while (per_start !== 1'b1 && wait_cnt < 1100) begin
                step();
                wait_cnt++;
            end
            check_output($sformatf("vec%0d_per_start", i), per_start, 1);
            highs = 0; shape = 0; steady = 0; first_pins = 2'b00;
            for (int j = 0; j < 1000; j++) begin
                step();
                if (j == 0) begin
                    first_pins = {in1, in2};
                    check_output($sformatf("vec%0d_stare_a", i), stare_a, vecs[i].exp_stare);
                end else if ({in1, in2} !== first_pins) steady++;
                if (pwm_a === 1'b1) highs++;
                case (vecs[i].exp_stare)
                    2'b00:   exp_bit = 1'b1;
                    2'b01:   exp_bit = 1'b0;
                    default: exp_bit = (j < vecs[i].exp_highs);
                endcase
                if (pwm_a !== exp_bit) shape++;
            end
            check_output($sformatf("vec%0d_pins_a", i), first_pins, vecs[i].exp_pins);
            check_output($sformatf("vec%0d_pwm_highs", i), highs, vecs[i].exp_highs);
            check_output($sformatf("vec%0d_pwm_shape_errs", i), shape, 0);
            check_output($sformatf("vec%0d_pins_changes", i), steady, 0);
            check_output($sformatf("vec%0d_chan_b_stop", i), {in3, in4, pwm_b, stare_b}, 5'b11100);
        end

        $display("[TB] asynchronous reset in RUN");
        do_reset();
        dir_a = 2'b10; duty_a = 12'h500;
        while (n < 1301) step();
        check_output("run_before_reset", {in1, in2, stare_a}, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_outputs", {in1, in2, in3, in4, pwm_a, pwm_b, stare_a, stare_b, per_start}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        step();
        check_output("post_reset_stop", {in1, in2, in3, in4, pwm_a, pwm_b, stare_a, stare_b}, 12'b1111_11_00_00);
        first_ps = -1;
        while (first_ps < 0 && n < 1100) begin
            step();
            if (per_start === 1'b1) first_ps = n;
        end
        check_output("first_per_start_cycle", first_ps, 1000);

        $display("[TB] randomized run against period model");
        do_reset();
        dir_a = 2'b10; duty_a = 12'h250;
        prev_a = 2'b00; prev_b = 2'b00;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            step();
            cur_a = {in1, in2};
            cur_b = {in3, in4};
            check_output("chan_a", {in1, in2, pwm_a, stare_a}, exp_chan(0));
            check_output("chan_b", {in3, in4, pwm_b, stare_b}, exp_chan(1));
            check_output("per_start", per_start, ((n % 1000) == 0));
            check_output("reversal_a", ((prev_a == 2'b10 && cur_a == 2'b01) || (prev_a == 2'b01 && cur_a == 2'b10)), 0);
            check_output("reversal_b", ((prev_b == 2'b10 && cur_b == 2'b01) || (prev_b == 2'b01 && cur_b == 2'b10)), 0);
            prev_a = cur_a;
            prev_b = cur_b;
            if (cyc >= 5000 && $urandom_range(0, 299) == 0) begin
                dir_a  = 2'($urandom_range(0, 3));
                duty_a = random_duty();
            end
            if ($urandom_range(0, 49) == 0) begin
                dir_b  = 2'($urandom_range(0, 3));
                duty_b = random_duty();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
